// File: rtl/c16_scancode_arbiter_if.sv
// Byte-source / keymatrix bus shared between the PS/2 receiver, the
// injector and the scancode arbiter. The arbiter is the slave; the byte
// sources and the keymatrix together form the master side.
interface c16_scancode_arbiter_if;
  logic [7:0] ps2_scancode;
  logic       ps2_valid;
  logic [7:0] inj_scancode;
  logic       inj_valid;
  logic       inj_ready;
  logic [7:0] scancode;
  logic       receiveflag;
  logic       ps2_overflow;
  logic       busy;

  modport master (
    output ps2_scancode, ps2_valid, inj_scancode, inj_valid,
    input  inj_ready, scancode, receiveflag, ps2_overflow, busy
  );

  modport slave (
    input  ps2_scancode, ps2_valid, inj_scancode, inj_valid,
    output inj_ready, scancode, receiveflag, ps2_overflow, busy
  );
endinterface

// File: rtl/c16_scancode_arbiter.sv
// Scancode arbiter for the C16 keyboard matrix. Merges PS/2 bytes (buffered
// in a small FIFO because the receiver cannot be stalled) with injector bytes
// (valid/ready handshake), keeps E0/F0 prefix sequences atomic per source and
// spaces output strobes at least GAP_CYCLES+1 cycles apart.
module c16_scancode_arbiter #(
  parameter int FIFO_DEPTH   = 8,
  parameter int GAP_CYCLES   = 3,
  parameter int LOCK_TIMEOUT = 65535
) (
  input logic                   clk,
  input logic                   reset,
  c16_scancode_arbiter_if.slave bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);

  localparam logic SRC_PS2 = 1'b0;
  localparam logic SRC_INJ = 1'b1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOCK_PS2 = 2'd1,
    LOCK_INJ = 2'd2
  } state_t;

  // E0 (extended) and F0 (break) open a multi-byte sequence.
  function automatic logic is_prefix(input logic [7:0] b);
    return (b == 8'hE0) || (b == 8'hF0);
  endfunction

  state_t          state;
  logic            last_src;
  logic [GW-1:0]   gap;
  logic [TW-1:0]   tcnt;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic [7:0]      out_byte;
  logic            out_flag;
  logic            ovf;
  logic            ready_en;   // holds inj_ready low in the cycle after reset

  logic            fifo_empty;
  logic            fifo_full;
  logic            issue_ok;
  logic            inj_ready_s;
  logic            inj_take;
  logic            ps2_take;
  logic            push_ok;
  logic            issue;
  logic [7:0]      issue_byte;
  logic            issue_prefix;

  assign fifo_empty   = (count == '0);
  assign fifo_full    = (count == (AW+1)'(FIFO_DEPTH));
  assign issue_ok     = (gap == '0);
  assign inj_take     = bus.inj_valid && inj_ready_s;
  assign ps2_take     = issue_ok && !fifo_empty &&
                        ((state == LOCK_PS2) || ((state == IDLE) && !inj_take));
  assign push_ok      = bus.ps2_valid && (!fifo_full || ps2_take);
  assign issue        = ps2_take || inj_take;
  assign issue_byte   = ps2_take ? mem[rd_ptr] : bus.inj_scancode;
  assign issue_prefix = is_prefix(issue_byte);

  // Injector may go only when the round-robin or its own lock allows; registered terms only.
  always_comb begin
    inj_ready_s = 1'b0;
    if (ready_en && issue_ok) begin
      case (state)
        IDLE:     inj_ready_s = fifo_empty || (last_src == SRC_PS2);
        LOCK_INJ: inj_ready_s = 1'b1;
        default:  inj_ready_s = 1'b0;
      endcase
    end else begin
      inj_ready_s = 1'b0;
    end
  end

  // FIFO storage; contents need no reset since the pointers are cleared.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= bus.ps2_scancode;
    end
  end

  // Arbitration FSM, FIFO pointers, gap/timeout counters and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      last_src <= SRC_INJ;
      gap      <= '0;
      tcnt     <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      out_byte <= 8'h00;
      out_flag <= 1'b0;
      ovf      <= 1'b0;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      out_flag <= 1'b0;

      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (bus.ps2_valid && !push_ok) begin
        ovf <= 1'b1;
      end
      if (ps2_take) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, ps2_take})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase

      if (issue) begin
        out_byte <= issue_byte;
        out_flag <= 1'b1;
        gap      <= GW'(GAP_CYCLES);
      end else if (gap != '0) begin
        gap <= gap - GW'(1);
      end

      case (state)
        IDLE: begin
          tcnt <= '0;
          if (ps2_take) begin
            if (issue_prefix) state <= LOCK_PS2;
            else              last_src <= SRC_PS2;
          end else if (inj_take) begin
            if (issue_prefix) state <= LOCK_INJ;
            else              last_src <= SRC_INJ;
          end
        end
        LOCK_PS2: begin
          if (ps2_take) begin
            tcnt <= '0;
            if (!issue_prefix) begin
              state    <= IDLE;
              last_src <= SRC_PS2;
            end
          end else if (tcnt == TW'(LOCK_TIMEOUT - 1)) begin
            tcnt     <= '0;
            state    <= IDLE;
            last_src <= SRC_PS2;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        LOCK_INJ: begin
          if (inj_take) begin
            tcnt <= '0;
            if (!issue_prefix) begin
              state    <= IDLE;
              last_src <= SRC_INJ;
            end
          end else if (tcnt == TW'(LOCK_TIMEOUT - 1)) begin
            tcnt     <= '0;
            state    <= IDLE;
            last_src <= SRC_INJ;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        default: begin
          state <= IDLE;
          tcnt  <= '0;
        end
      endcase
    end
  end

  assign bus.inj_ready    = inj_ready_s;
  assign bus.scancode     = out_byte;
  assign bus.receiveflag  = out_flag;
  assign bus.ps2_overflow = ovf;
  assign bus.busy         = (state != IDLE) || !fifo_empty || (gap != '0);

endmodule

// File: tb/tb_c16_scancode_arbiter.sv
// Directed bench for c16_scancode_arbiter: each scenario task drives its own
// stimulus and compares the strobe log and outputs to hand-derived values.
module tb_c16_scancode_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b0;
  c16_scancode_arbiter_if bus();

  c16_scancode_arbiter #(
    .FIFO_DEPTH  (8),
    .GAP_CYCLES  (3),
    .LOCK_TIMEOUT(20)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int         cyc = 0;
  int         chk_cnt = 0;
  int         pass_cnt = 0;
  logic [7:0] log_d[$];
  int         log_c[$];
  logic [7:0] inj_q[$];
  int         rdy_hi;
  int         rdy_double;
  logic       rdy_prev;

  // Edge counter: value after an edge identifies that edge.
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe recorder, sampled away from the active edge.
  always @(negedge clk) begin
    if (bus.receiveflag) begin
      log_d.push_back(bus.scancode);
      log_c.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_inj();
    if (inj_q.size() > 0) begin
      bus.inj_scancode = inj_q.pop_front();
      bus.inj_valid    = 1'b1;
    end
  endtask

  // Advance n cycles, feeding the next queued injector byte after each acceptance.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      logic take;
      take = bus.inj_valid && bus.inj_ready;
      if (bus.inj_valid) begin
        if (bus.inj_ready) rdy_hi++;
        if (bus.inj_ready && rdy_prev) rdy_double++;
      end
      rdy_prev = bus.inj_ready;
      tick();
      if (take) begin
        if (inj_q.size() > 0) bus.inj_scancode = inj_q.pop_front();
        else                  bus.inj_valid = 1'b0;
      end
    end
  endtask

  task automatic apply_reset();
    bus.ps2_valid    = 1'b0;
    bus.ps2_scancode = 8'h00;
    bus.inj_valid    = 1'b0;
    bus.inj_scancode = 8'h00;
    inj_q.delete();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    log_d.delete();
    log_c.delete();
    rdy_hi = 0;
    rdy_double = 0;
    rdy_prev = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    chk_cnt++; if (bus.scancode !== 8'h00) $display("FAIL rst_scancode got %h exp 00", bus.scancode); else pass_cnt++;
    chk_cnt++; if (bus.receiveflag !== 1'b0) $display("FAIL rst_receiveflag got %b exp 0", bus.receiveflag); else pass_cnt++;
    chk_cnt++; if (bus.inj_ready !== 1'b0) $display("FAIL rst_inj_ready got %b exp 0", bus.inj_ready); else pass_cnt++;
    chk_cnt++; if (bus.ps2_overflow !== 1'b0) $display("FAIL rst_overflow got %b exp 0", bus.ps2_overflow); else pass_cnt++;
    chk_cnt++; if (bus.busy !== 1'b0) $display("FAIL rst_busy got %b exp 0", bus.busy); else pass_cnt++;
  endtask

  task automatic test_single_ps2();
    int a;
    apply_reset();
    bus.ps2_scancode = 8'h1C; bus.ps2_valid = 1'b1;
    tick();
    a = cyc;
    bus.ps2_valid = 1'b0;
    run(9);
    chk_cnt++; if (log_d.size() != 1) $display("FAIL single_count got %0d exp 1", log_d.size()); else pass_cnt++;
    chk_cnt++; if (log_d[0] !== 8'h1C) $display("FAIL single_data got %h exp 1c", log_d[0]); else pass_cnt++;
    chk_cnt++; if (log_c[0] - a != 1) $display("FAIL single_latency got %0d exp 1", log_c[0] - a); else pass_cnt++;
    chk_cnt++; if (bus.inj_ready !== 1'b1) $display("FAIL single_inj_ready got %b exp 1", bus.inj_ready); else pass_cnt++;
    chk_cnt++; if (bus.busy !== 1'b0) $display("FAIL single_busy got %b exp 0", bus.busy); else pass_cnt++;
  endtask

  task automatic test_prefix_lock();
    int a;
    int bad;
    apply_reset();
    bus.ps2_scancode = 8'hF0; bus.ps2_valid = 1'b1;
    tick();
    a = cyc;
    bus.ps2_scancode = 8'h1C;
    inj_q.push_back(8'h32);
    start_inj();
    chk_cnt++; if (bus.inj_ready !== 1'b0) $display("FAIL lock_ready_initial got %b exp 0", bus.inj_ready); else pass_cnt++;
    run(1);
    bus.ps2_valid = 1'b0;
    bad = 0;
    for (int i = 0; i < 13; i++) begin
      if (bus.inj_ready && log_d.size() < 2) bad++;
      run(1);
    end
    chk_cnt++; if (bad != 0) $display("FAIL lock_ready_early got %0d exp 0", bad); else pass_cnt++;
    chk_cnt++; if (log_d.size() != 3) $display("FAIL lock_count got %0d exp 3", log_d.size()); else pass_cnt++;
    chk_cnt++; if (log_d[0] !== 8'hF0) $display("FAIL lock_b0 got %h exp f0", log_d[0]); else pass_cnt++;
    chk_cnt++; if (log_d[1] !== 8'h1C) $display("FAIL lock_b1 got %h exp 1c", log_d[1]); else pass_cnt++;
    chk_cnt++; if (log_d[2] !== 8'h32) $display("FAIL lock_b2 got %h exp 32", log_d[2]); else pass_cnt++;
    chk_cnt++; if (log_c[0] - a != 1) $display("FAIL lock_t0 got %0d exp 1", log_c[0] - a); else pass_cnt++;
    chk_cnt++; if (log_c[1] - log_c[0] != 4) $display("FAIL lock_gap01 got %0d exp 4", log_c[1] - log_c[0]); else pass_cnt++;
    chk_cnt++; if (log_c[2] - log_c[1] != 4) $display("FAIL lock_gap12 got %0d exp 4", log_c[2] - log_c[1]); else pass_cnt++;
  endtask

  task automatic test_round_robin();
    int b;
    apply_reset();
    bus.ps2_scancode = 8'h29; bus.ps2_valid = 1'b1;
    tick();
    b = cyc;
    bus.ps2_scancode = 8'h1B;
    inj_q.push_back(8'h1A);
    start_inj();
    run(1);
    bus.ps2_valid = 1'b0;
    run(11);
    chk_cnt++; if (log_d.size() != 3) $display("FAIL rr_count got %0d exp 3", log_d.size()); else pass_cnt++;
    chk_cnt++; if (log_d[0] !== 8'h29) $display("FAIL rr_b0 got %h exp 29", log_d[0]); else pass_cnt++;
    chk_cnt++; if (log_d[1] !== 8'h1A) $display("FAIL rr_b1 got %h exp 1a", log_d[1]); else pass_cnt++;
    chk_cnt++; if (log_d[2] !== 8'h1B) $display("FAIL rr_b2 got %h exp 1b", log_d[2]); else pass_cnt++;
    chk_cnt++; if (log_c[1] - b != 5) $display("FAIL rr_t1 got %0d exp 5", log_c[1] - b); else pass_cnt++;
    chk_cnt++; if (log_c[2] - b != 9) $display("FAIL rr_t2 got %0d exp 9", log_c[2] - b); else pass_cnt++;
  endtask

  task automatic test_overflow_timeout();
    int bad;
    int dt;
    apply_reset();
    tick();
    inj_q.push_back(8'hE0);
    start_inj();
    run(1);
    for (int i = 0; i < 9; i++) begin
      bus.ps2_scancode = 8'h11 + 8'(i);
      bus.ps2_valid = 1'b1;
      tick();
    end
    bus.ps2_valid = 1'b0;
    chk_cnt++; if (bus.ps2_overflow !== 1'b1) $display("FAIL ovf_flag got %b exp 1", bus.ps2_overflow); else pass_cnt++;
    chk_cnt++; if (log_d.size() != 1) $display("FAIL ovf_locked_count got %0d exp 1", log_d.size()); else pass_cnt++;
    run(50);
    chk_cnt++; if (log_d.size() != 9) $display("FAIL ovf_count got %0d exp 9", log_d.size()); else pass_cnt++;
    chk_cnt++; if (log_d[0] !== 8'hE0) $display("FAIL ovf_first got %h exp e0", log_d[0]); else pass_cnt++;
    bad = 0;
    for (int i = 1; i < 9; i++) begin
      if (log_d[i] !== 8'h10 + 8'(i)) bad++;
    end
    chk_cnt++; if (bad != 0) $display("FAIL ovf_order got %0d wrong exp 0", bad); else pass_cnt++;
    dt = log_c[1] - log_c[0];
    chk_cnt++; if (dt < 20 || dt > 22) $display("FAIL ovf_timeout got %0d exp 20..22", dt); else pass_cnt++;
    chk_cnt++; if (bus.ps2_overflow !== 1'b1) $display("FAIL ovf_sticky got %b exp 1", bus.ps2_overflow); else pass_cnt++;
    chk_cnt++; if (bus.busy !== 1'b0) $display("FAIL ovf_busy_end got %b exp 0", bus.busy); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    apply_reset();
    tick();
    inj_q.push_back(8'h16);
    inj_q.push_back(8'h1E);
    inj_q.push_back(8'h26);
    start_inj();
    run(16);
    chk_cnt++; if (log_d.size() != 3) $display("FAIL b2b_count got %0d exp 3", log_d.size()); else pass_cnt++;
    chk_cnt++; if (log_d[0] !== 8'h16) $display("FAIL b2b_b0 got %h exp 16", log_d[0]); else pass_cnt++;
    chk_cnt++; if (log_d[1] !== 8'h1E) $display("FAIL b2b_b1 got %h exp 1e", log_d[1]); else pass_cnt++;
    chk_cnt++; if (log_d[2] !== 8'h26) $display("FAIL b2b_b2 got %h exp 26", log_d[2]); else pass_cnt++;
    chk_cnt++; if (log_c[1] - log_c[0] != 4) $display("FAIL b2b_gap01 got %0d exp 4", log_c[1] - log_c[0]); else pass_cnt++;
    chk_cnt++; if (log_c[2] - log_c[1] != 4) $display("FAIL b2b_gap12 got %0d exp 4", log_c[2] - log_c[1]); else pass_cnt++;
    chk_cnt++; if (rdy_hi != 3) $display("FAIL b2b_ready_cycles got %0d exp 3", rdy_hi); else pass_cnt++;
    chk_cnt++; if (rdy_double != 0) $display("FAIL b2b_ready_pulse got %0d exp 0", rdy_double); else pass_cnt++;
  endtask

  task automatic test_reset_mid_lock();
    int d;
    apply_reset();
    bus.ps2_scancode = 8'hF0; bus.ps2_valid = 1'b1;
    tick();
    bus.ps2_scancode = 8'h11; run(1);
    bus.ps2_scancode = 8'h22; run(1);
    bus.ps2_scancode = 8'h33; run(1);
    bus.ps2_valid = 1'b0;
    chk_cnt++; if (bus.busy !== 1'b1) $display("FAIL mid_busy got %b exp 1", bus.busy); else pass_cnt++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_cnt++; if (bus.scancode !== 8'h00) $display("FAIL mid_scancode got %h exp 00", bus.scancode); else pass_cnt++;
    chk_cnt++; if (bus.receiveflag !== 1'b0) $display("FAIL mid_receiveflag got %b exp 0", bus.receiveflag); else pass_cnt++;
    chk_cnt++; if (bus.inj_ready !== 1'b0) $display("FAIL mid_inj_ready got %b exp 0", bus.inj_ready); else pass_cnt++;
    chk_cnt++; if (bus.busy !== 1'b0) $display("FAIL mid_busy_after got %b exp 0", bus.busy); else pass_cnt++;
    log_d.delete();
    log_c.delete();
    run(12);
    chk_cnt++; if (log_d.size() != 0) $display("FAIL mid_no_strobe got %0d exp 0", log_d.size()); else pass_cnt++;
    bus.ps2_scancode = 8'h5A; bus.ps2_valid = 1'b1;
    tick();
    d = cyc;
    bus.ps2_valid = 1'b0;
    run(3);
    chk_cnt++; if (log_d.size() != 1) $display("FAIL mid_post_count got %0d exp 1", log_d.size()); else pass_cnt++;
    chk_cnt++; if (log_d[0] !== 8'h5A) $display("FAIL mid_post_data got %h exp 5a", log_d[0]); else pass_cnt++;
    chk_cnt++; if (log_c[0] - d != 1) $display("FAIL mid_post_latency got %0d exp 1", log_c[0] - d); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single_ps2();
    test_prefix_lock();
    test_round_robin();
    test_overflow_timeout();
    test_back_to_back();
    test_reset_mid_lock();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
